// File: rtl/byte_lane_memory.sv
// byte_lane_memory: big-endian byte-lane memory with four-phase handshake and swap-on-write
module byte_lane_memory #(
  parameter int DATA_BYTES  = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 65536
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    we,
  input  logic [1:0]              size,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [8*DATA_BYTES-1:0] wdata,
  output logic                    ack,
  output logic                    error,
  output logic [8*DATA_BYTES-1:0] rdata
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int OW = $clog2(DATA_BYTES);
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] mem [DEPTH_WORDS];
  logic [IW-1:0] idx_q;
  logic [OW-1:0] k_q;
  logic [1:0]    size_q;
  logic          we_q;
  logic [DW-1:0] wdata_q, hold, low, wr_word;
  logic [3:0]    n_in, n_q;
  logic [6:0]    sh;
  logic          legal;
  assign n_in  = 4'd1 << size;
  assign legal = (int'(n_in) <= DATA_BYTES) && ((addr & ADDR_WIDTH'(n_in - 4'd1)) == '0) &&
                 ((addr >> OW) < ADDR_WIDTH'(DEPTH_WORDS));
  assign n_q     = 4'd1 << size_q;
  assign sh      = 7'(8 * (DATA_BYTES - int'(k_q) - int'(n_q)));
  assign low     = (DW'(1) << {n_q, 3'b000}) - DW'(1);
  assign wr_word = (hold & ~(low << sh)) | ((wdata_q & low) << sh);
  assign ack     = state == DONE;
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // next-state: accept in IDLE, optional write pass, hold DONE until req drops
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req ? (legal ? READ : DONE) : IDLE;
      READ:    state_n = we_q ? WRITE : DONE;
      WRITE:   state_n = DONE;
      default: state_n = req ? DONE : IDLE;
    endcase
  end
  // request latch, holding register and response
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      k_q     <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      hold    <= '0;
      error   <= 1'b0;
      rdata   <= '0;
    end else if (state == IDLE && req) begin
      idx_q   <= addr[OW +: IW];
      k_q     <= addr[OW-1:0];
      size_q  <= size;
      we_q    <= we;
      wdata_q <= wdata;
      error   <= !legal;
      rdata   <= '0;
    end else if (state == READ) begin
      hold  <= mem[idx_q];
      rdata <= (mem[idx_q] >> sh) & low;
    end
  end
  // storage write; a reset on the same edge suppresses it
  always_ff @(posedge clk) if (!reset && state == WRITE) mem[idx_q] <= wr_word;
endmodule

// File: tb/tb_byte_lane_memory.sv
// tb_byte_lane_memory: directed checks of the 4-byte and 8-byte lane memory
module tb_byte_lane_memory;
  logic        clk = 0, reset = 1, req4 = 0, req8 = 0, we = 0;
  logic [1:0]  size = 0;
  logic [31:0] addr = 0;
  logic [63:0] wd = 0;
  logic        ack4, err4, ack8, err8;
  logic [31:0] rd4;
  logic [63:0] rd8;
  int checks = 0, errors = 0;

  byte_lane_memory #(.DATA_BYTES(4), .ADDR_WIDTH(32), .DEPTH_WORDS(16)) d4 (
    .clk(clk), .reset(reset), .req(req4), .we(we), .size(size), .addr(addr),
    .wdata(wd[31:0]), .ack(ack4), .error(err4), .rdata(rd4));
  byte_lane_memory #(.DATA_BYTES(8), .ADDR_WIDTH(32), .DEPTH_WORDS(16)) d8 (
    .clk(clk), .reset(reset), .req(req8), .we(we), .size(size), .addr(addr),
    .wdata(wd), .ack(ack8), .error(err8), .rdata(rd8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic acc(input bit s, input bit w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [63:0] d, input int lat, input bit e, input logic [63:0] rd,
                     input bit crd, input int hold_cycles, input string tag);
    int n = 0;
    @(negedge clk);
    we = w; size = sz; addr = a; wd = d;
    if (s) req8 = 1; else req4 = 1;
    do begin
      @(posedge clk); #1; n++;
    end while (!(s ? ack8 : ack4) && n < 10);
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " error"}, 64'(s ? err8 : err4), 64'(e));
    if (crd) chk({tag, " rdata"}, s ? rd8 : {32'b0, rd4}, rd);
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk); #1;
      chk({tag, " held ack"}, 64'(s ? ack8 : ack4), 64'd1);
      chk({tag, " held rdata"}, s ? rd8 : {32'b0, rd4}, rd);
    end
    @(negedge clk);
    req4 = 0; req8 = 0;
    @(posedge clk); #1;
    chk({tag, " ack drop"}, 64'(s ? ack8 : ack4), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", 64'(ack4), 64'd0);
    chk("reset error", 64'(err4), 64'd0);
    chk("reset rdata", 64'(rd4), 64'd0);
    @(negedge clk); reset = 0;
    acc(0, 1, 2, 32'h10, 64'h0, 3, 0, 0, 0, 0, "init w0");
    acc(0, 1, 2, 32'h10, 64'h11223344, 3, 0, 64'h0, 1, 0, "word write");
    acc(0, 0, 0, 32'h12, 64'h0, 2, 0, 64'h33, 1, 0, "byte read");
    acc(0, 1, 1, 32'h12, 64'hAABB, 3, 0, 64'h3344, 1, 0, "half swap");
    acc(0, 0, 2, 32'h10, 64'h0, 2, 0, 64'h1122AABB, 1, 0, "word read");
    acc(0, 1, 1, 32'h13, 64'h9999, 1, 1, 64'h0, 1, 0, "misaligned half");
    acc(0, 0, 2, 32'h11, 64'h0, 1, 1, 64'h0, 1, 0, "misaligned word");
    acc(0, 0, 0, 32'h40, 64'h0, 1, 1, 64'h0, 1, 0, "index 16");
    acc(0, 1, 3, 32'h10, 64'h0, 1, 1, 64'h0, 1, 0, "dword on 4B");
    acc(0, 0, 0, 32'h3F, 64'h0, 2, 0, 64'h0, 0, 0, "last byte");
    acc(0, 0, 2, 32'h10, 64'h0, 2, 0, 64'h1122AABB, 1, 0, "after errors");
    @(negedge clk);
    we = 1; size = 2; addr = 32'h10; wd = 64'hDEADBEEF; req4 = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("in write ack", 64'(ack4), 64'd0);
    @(negedge clk); reset = 1; req4 = 0;
    @(posedge clk); #1;
    chk("abort ack", 64'(ack4), 64'd0);
    chk("abort rdata", 64'(rd4), 64'd0);
    @(negedge clk); reset = 0;
    acc(0, 0, 2, 32'h10, 64'h0, 2, 0, 64'h1122AABB, 1, 0, "after abort");
    acc(0, 1, 1, 32'h10, 64'h5566, 3, 0, 64'h1122, 1, 5, "hold");
    acc(0, 0, 2, 32'h10, 64'h0, 2, 0, 64'h5566AABB, 1, 0, "post hold");
    acc(0, 1, 0, 32'h13, 64'hCC, 3, 0, 64'hBB, 1, 0, "byte swap");
    acc(0, 0, 2, 32'h10, 64'h0, 2, 0, 64'h5566AACC, 1, 0, "byte merged");
    acc(1, 1, 3, 32'h8, 64'h0, 3, 0, 0, 0, 0, "d8 init");
    acc(1, 1, 3, 32'h8, 64'h0102030405060708, 3, 0, 64'h0, 1, 0, "d8 dword write");
    acc(1, 0, 1, 32'hE, 64'h0, 2, 0, 64'h0708, 1, 0, "d8 half read");
    acc(1, 0, 2, 32'hC, 64'h0, 2, 0, 64'h05060708, 1, 0, "d8 word read");
    acc(1, 0, 3, 32'h8, 64'h0, 2, 0, 64'h0102030405060708, 1, 0, "d8 dword read");
    acc(1, 0, 3, 32'h80, 64'h0, 1, 1, 64'h0, 1, 0, "d8 index 16");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
